// File: rtl/mem_port_arbiter_if.sv
// Port bundle between the two LEGv8 requesters, the shared data-memory port and the arbiter.
// The slave view is the arbiter itself; the master view is whatever drives the requests and memory.
interface mem_port_arbiter_if #(
    parameter int N = 64
);
    logic         req_a;
    logic [N-1:0] addr_a;
    logic [N-1:0] wdata_a;
    logic         we_a;
    logic         req_b;
    logic [N-1:0] addr_b;
    logic [N-1:0] wdata_b;
    logic         we_b;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_wdata;
    logic         mem_we;
    logic         mem_valid;
    logic         mem_ready;
    logic [N-1:0] mem_rdata;
    logic [N-1:0] rdata;
    logic         done_a;
    logic         done_b;
    logic         sel;
    logic         busy;

    modport slave (
        input  req_a, addr_a, wdata_a, we_a,
        input  req_b, addr_b, wdata_b, we_b,
        input  mem_ready, mem_rdata,
        output mem_addr, mem_wdata, mem_we, mem_valid,
        output rdata, done_a, done_b, sel, busy
    );

    modport master (
        output req_a, addr_a, wdata_a, we_a,
        output req_b, addr_b, wdata_b, we_b,
        output mem_ready, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, mem_valid,
        input  rdata, done_a, done_b, sel, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between fetch (A) and load/store (B).
// One transaction in flight; every output comes straight from a register.
module mem_port_arbiter #(
    parameter int N            = 64,
    parameter bit RESET_LAST_B = 1'b1
) (
    input logic            clk,
    input logic            reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t       state_q, state_d;
    logic [N-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0] mem_wdata_q, mem_wdata_d;
    logic [N-1:0] rdata_q, rdata_d;
    logic         mem_we_q, mem_we_d;
    logic         mem_valid_q, mem_valid_d;
    logic         done_a_q, done_a_d;
    logic         done_b_q, done_b_d;
    logic         sel_q, sel_d;
    logic         busy_q, busy_d;
    logic         last_b_q, last_b_d;
    logic         any_req;
    logic         grant_b;

    // On a tie B wins only if A was served last.
    assign any_req = bus.req_a | bus.req_b;
    assign grant_b = bus.req_b & (~bus.req_a | ~last_b_q);

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            sel_q       <= 1'b0;
            busy_q      <= 1'b0;
            last_b_q    <= RESET_LAST_B;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            mem_we_q    <= mem_we_d;
            mem_valid_q <= mem_valid_d;
            done_a_q    <= done_a_d;
            done_b_q    <= done_b_d;
            sel_q       <= sel_d;
            busy_q      <= busy_d;
            last_b_q    <= last_b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (bus.mem_ready) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every signal gets a hold/default value first so no path through the case infers a latch.
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        mem_we_d    = mem_we_q;
        mem_valid_d = mem_valid_q;
        sel_d       = sel_q;
        busy_d      = busy_q;
        last_b_d    = last_b_q;
        done_a_d    = 1'b0;
        done_b_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    sel_d       = grant_b;
                    mem_addr_d  = grant_b ? bus.addr_b  : bus.addr_a;
                    mem_wdata_d = grant_b ? bus.wdata_b : bus.wdata_a;
                    mem_we_d    = grant_b ? bus.we_b    : bus.we_a;
                    mem_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    if (!mem_we_q) rdata_d = bus.mem_rdata;
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    done_a_d    = ~sel_q;
                    done_b_d    = sel_q;
                    last_b_d    = sel_q;
                end
            end
            RESP:    busy_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.rdata     = rdata_q;
    assign bus.done_a    = done_a_q;
    assign bus.done_b    = done_b_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset abort, single read/write, tie alternation,
// stall stability and spurious mem_ready, with hand-computed expectations.
module tb_mem_port_arbiter;
    localparam int N = 64;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mem_port_arbiter_if #(.N(N)) bus ();

    mem_port_arbiter #(.N(N), .RESET_LAST_B(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 ns after the rising edge; inputs set afterwards are seen at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        bus.req_a     = 1'b0;
        bus.addr_a    = '0;
        bus.wdata_a   = '0;
        bus.we_a      = 1'b0;
        bus.req_b     = 1'b0;
        bus.addr_b    = '0;
        bus.wdata_b   = '0;
        bus.we_b      = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) tick();

        check("rst_valid", N'(bus.mem_valid), 64'd0);
        check("rst_busy",  N'(bus.busy),      64'd0);
        check("rst_sel",   N'(bus.sel),       64'd0);
        check("rst_done",  N'({bus.done_a, bus.done_b}), 64'd0);
        check("rst_addr",  bus.mem_addr,  64'd0);
        check("rst_rdata", bus.rdata,     64'd0);
        reset = 1'b1;

        // Reset in the middle of an access aborts it immediately.
        bus.req_a  = 1'b1;
        bus.addr_a = 64'h40;
        tick();
        check("abort_pre_valid", N'(bus.mem_valid), 64'd1);
        tick();
        #2 reset = 1'b0;
        #1;
        check("abort_valid", N'(bus.mem_valid), 64'd0);
        check("abort_busy",  N'(bus.busy),      64'd0);
        check("abort_done",  N'({bus.done_a, bus.done_b}), 64'd0);
        bus.req_a = 1'b0;
        tick();
        reset = 1'b1;

        // First tie after reset goes to A.
        bus.req_a  = 1'b1;
        bus.req_b  = 1'b1;
        bus.addr_a = 64'h100;
        bus.addr_b = 64'h200;
        tick();
        check("tie0_sel",  N'(bus.sel), 64'd0);
        check("tie0_addr", bus.mem_addr, 64'h100);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h1111;
        tick();
        check("tie0_done_a", N'(bus.done_a), 64'd1);
        bus.req_a     = 1'b0;
        bus.req_b     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("tie0_idle_busy", N'(bus.busy), 64'd0);

        // Single read from A, memory answers on the second ACCESS cycle.
        bus.req_a  = 1'b1;
        bus.addr_a = 64'h0000_0000_0000_0040;
        bus.we_a   = 1'b0;
        tick();
        check("rda_sel",   N'(bus.sel),       64'd0);
        check("rda_addr",  bus.mem_addr,      64'h40);
        check("rda_valid", N'(bus.mem_valid), 64'd1);
        check("rda_we",    N'(bus.mem_we),    64'd0);
        tick();
        check("rda_stall_done", N'(bus.done_a), 64'd0);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hDEAD_BEEF_0000_0001;
        tick();
        check("rda_done_a", N'(bus.done_a),    64'd1);
        check("rda_done_b", N'(bus.done_b),    64'd0);
        check("rda_rdata",  bus.rdata,         64'hDEAD_BEEF_0000_0001);
        check("rda_vdrop",  N'(bus.mem_valid), 64'd0);
        check("rda_resp_busy", N'(bus.busy),   64'd1);
        bus.req_a     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();
        check("rda_pulse_end", N'(bus.done_a), 64'd0);
        check("rda_idle_busy", N'(bus.busy),   64'd0);

        // Single write from B, memory ready in the first ACCESS cycle.
        bus.req_b     = 1'b1;
        bus.addr_b    = 64'h80;
        bus.wdata_b   = 64'h1234;
        bus.we_b      = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h9999;
        tick();
        check("wrb_sel",   N'(bus.sel),    64'd1);
        check("wrb_we",    N'(bus.mem_we), 64'd1);
        check("wrb_wdata", bus.mem_wdata,  64'h1234);
        check("wrb_addr",  bus.mem_addr,   64'h80);
        tick();
        check("wrb_done_b", N'(bus.done_b), 64'd1);
        check("wrb_done_a", N'(bus.done_a), 64'd0);
        check("wrb_rdata",  bus.rdata,      64'hDEAD_BEEF_0000_0001);
        check("wrb_we_clr", N'(bus.mem_we), 64'd0);
        bus.req_b     = 1'b0;
        bus.we_b      = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // Continuous tie: B was served last, so grants run A,B,A,B.
        bus.req_a     = 1'b1;
        bus.req_b     = 1'b1;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rr%0d_sel", i), N'(bus.sel), N'(i % 2));
            check($sformatf("rr%0d_valid", i), N'(bus.mem_valid), 64'd1);
            tick();
            check($sformatf("rr%0d_done_a", i), N'(bus.done_a), N'(i % 2 == 0));
            check($sformatf("rr%0d_done_b", i), N'(bus.done_b), N'(i % 2 == 1));
            if (i == 3) begin
                bus.req_a = 1'b0;
                bus.req_b = 1'b0;
            end
            tick();
            check($sformatf("rr%0d_idle", i), N'(bus.busy), 64'd0);
        end
        bus.mem_ready = 1'b0;

        // Stall: grant A on a tie, scramble inputs and drop req_a; the port must not move.
        bus.req_a   = 1'b1;
        bus.req_b   = 1'b1;
        bus.addr_a  = 64'h400;
        bus.wdata_a = 64'h11;
        bus.addr_b  = 64'h300;
        bus.wdata_b = 64'h55;
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.addr_a  = 64'h500 + 64'(i);
            bus.addr_b  = 64'h600 + 64'(i);
            bus.wdata_a = 64'h700 + 64'(i);
            if (i == 5) bus.req_a = 1'b0;
            tick();
            check($sformatf("stall%0d_addr", i),  bus.mem_addr,      64'h400);
            check($sformatf("stall%0d_wdata", i), bus.mem_wdata,     64'h11);
            check($sformatf("stall%0d_sel", i),   N'(bus.sel),       64'd0);
            check($sformatf("stall%0d_valid", i), N'(bus.mem_valid), 64'd1);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'hCAFE_F00D_0000_0002;
        tick();
        check("stall_done_a", N'(bus.done_a), 64'd1);
        check("stall_rdata",  bus.rdata,      64'hCAFE_F00D_0000_0002);
        bus.req_b     = 1'b0;
        bus.mem_ready = 1'b0;
        tick();

        // mem_ready in IDLE with no request changes nothing.
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 64'h0BAD;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("spur%0d_busy", i),  N'(bus.busy),      64'd0);
            check($sformatf("spur%0d_valid", i), N'(bus.mem_valid), 64'd0);
            check($sformatf("spur%0d_done", i),  N'({bus.done_a, bus.done_b}), 64'd0);
            check($sformatf("spur%0d_rdata", i), bus.rdata, 64'hCAFE_F00D_0000_0002);
        end
        bus.mem_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
